regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side front end of the integer register file. It merges results from the ALU and the load/store unit onto the register file's single write port (valid, 6-bit address, XLEN data). ALU results bypass a queue, and load results wait in a small FIFO. A starvation limit guarantees forward progress for loads. Two hazard outputs let decode see which read addresses have a write still in flight.

## Interface

Parameters:
- XLEN, 32: data width.
- FIFO_DEPTH, 4: load-result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 4: number of consecutive ALU grants while the FIFO is non-empty before a load is forced.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU result valid.
- alu_adr_i  in  6  ALU destination address.
- alu_data_i  in  XLEN  ALU result.
- alu_ready_o  out  1  ALU result accepted this cycle when high together with alu_valid_i.
- lsu_valid_i  in  1  load result valid.
- lsu_adr_i  in  6  load destination address.
- lsu_data_i  in  XLEN  load data.
- lsu_ready_o  out  1  low when the FIFO is full.
- read_adr0_i, read_adr1_i  in  6  decode source addresses to check.
- pend0_o, pend1_o  out  1  a write to that address is queued or in the output register.
- write_valid_o  out  1  register-file write enable (registered).
- write_adr_o  out  6  register-file write address (registered).
- write_data_o  out  XLEN  register-file write data (registered).

## Operation

- Reset (reset=1 at a rising edge): FIFO empties, pointers and count go to 0, starvation counter goes to 0, and write_valid_o/write_adr_o/write_data_o go to 0.
  - After reset: lsu_ready_o=1, alu_ready_o=1, pend0_o=pend1_o=0.
  - A reset asserted mid-operation discards all queued loads without writing them.
- lsu_ready_o = (count != FIFO_DEPTH).
  - Depends only on count, not on same-cycle pop. At full with a pop in progress, ready is still 0.
- LSU handshake (lsu_valid_i & lsu_ready_o):
  - lsu_adr_i != 0: {adr, data} is pushed at the tail.
  - lsu_adr_i == 0: the result is accepted and discarded (x0 is hardwired), with no push.
- Grant each cycle, evaluated in this order:
  1. force = FIFO non-empty & starv_cnt == STARVE_LIMIT. Grant the FIFO head; alu_ready_o=0.
  2. Else if alu_valid_i: grant the ALU; alu_ready_o=1.
  3. Else if FIFO non-empty: grant the FIFO head; alu_ready_o=1.
  4. Else: no grant; alu_ready_o=1.
- alu_ready_o is 0 only in the force case.
- On a grant, the output register loads the winner's {adr, data}.
  - write_valid_o is set to 1 unless the granted address is 0. An ALU write to x0 yields write_valid_o=0 next cycle.
  - A FIFO grant pops the head.
  - With no grant, write_valid_o goes to 0; adr/data hold their previous values.
- Starvation counter:
  - Increments when the ALU is granted and the FIFO is non-empty.
  - Clears when the FIFO is granted or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- A same-cycle push and pop are both honoured; count is unchanged.
  - A push into an empty FIFO is not visible to the grant logic until the next cycle.
- Hazard outputs (combinational):
  - pendK_o = (read_adrK_i != 0) & (it matches any valid FIFO entry, or write_valid_o & write_adr_o).
- Ordering: a later load to the same address always writes after an earlier one (FIFO order). No ordering is enforced between the ALU and LSU streams.

## Timing

- ALU result accepted in cycle N: write_valid_o=1 in cycle N+1, for exactly 1 cycle per result.
- LSU result pushed into an empty FIFO in cycle N with no ALU traffic: granted in N+1, write port in N+2.
- Maximum load wait with continuous ALU traffic and a non-empty FIFO: STARVE_LIMIT ALU grants, then 1 forced load.
- Sustained throughput: 1 write per cycle.
- pend is combinational from FIFO contents and the output register. It drops the cycle after the write leaves the output register.

## Test plan

- Reset check: assert reset for 2 cycles mid-traffic with 3 loads queued. Required after reset: write_valid_o=0, lsu_ready_o=1, pend0_o=0, and none of the 3 loads is ever written.
- ALU path: alu_valid_i=1, adr=5, data=0xDEADBEEF in cycle N. Required in N+1: write_valid_o=1, write_adr_o=5, write_data_o=0xDEADBEEF. In N+2, with no new input: write_valid_o=0.
- Load FIFO fill: push 4 loads (adr 1..4) with alu_valid_i held at 1.
  - After the 4th push, lsu_ready_o=0.
  - Forced drain after 4 ALU grants: alu_ready_o=0 for 1 cycle, then write_adr_o=1.
  - All four loads eventually written in order 1, 2, 3, 4.
- x0 handling: ALU write to adr 0 gives write_valid_o=0 the next cycle. LSU write to adr 0 is accepted with count unchanged.
- Hazards: queue a load to adr 7 and set read_adr0_i=7. Required: pend0_o=1 until the cycle after write_adr_o=7 is written, then 0. read_adr1_i=0 always gives pend1_o=0.
- Full boundary: at count=4, with a pop and lsu_valid_i=1 in the same cycle, the load is not accepted (lsu_ready_o=0). The next cycle it is accepted and count returns to 4.

Source files
------------

// File: rtl/regfile_writeback.sv
// Merges ALU results and FIFO-queued load results onto the single RF write port; ALU writes land 1 cycle after acceptance, loads at least 2.
// Backpressure: lsu_ready_o drops while the load FIFO is full; alu_ready_o drops only in a cycle that forces a starved load through.
module regfile_writeback #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid_i,
    input  logic [5:0]      alu_adr_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [5:0]      lsu_adr_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
    input  logic [5:0]      read_adr0_i,
    input  logic [5:0]      read_adr1_i,
    output logic            pend0_o,
    output logic            pend1_o,
    output logic            write_valid_o,
    output logic [5:0]      write_adr_o,
    output logic [XLEN-1:0] write_data_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [5:0]      fifo_adr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_dat [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [SW-1:0]   starv_cnt;

    logic            fifo_nempty;
    logic            force_ld;
    logic            grant_alu;
    logic            grant_fifo;
    logic            push;
    logic [FIFO_DEPTH-1:0] ent_vld;

    assign fifo_nempty = (count != '0);
    assign force_ld    = fifo_nempty && (starv_cnt == SW'(STARVE_LIMIT));
    assign grant_alu   = alu_valid_i && !force_ld;
    assign grant_fifo  = fifo_nempty && !grant_alu;
    assign alu_ready_o = !force_ld;
    assign lsu_ready_o = (count != (PW+1)'(FIFO_DEPTH));
    // Loads to x0 complete the handshake but never occupy a slot.
    assign push        = lsu_valid_i && lsu_ready_o && (lsu_adr_i != 6'd0);

    always_comb begin
        ent_vld = '0;
        pend0_o = 1'b0;
        pend1_o = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < count);
            if (ent_vld[i] && (fifo_adr[i] == read_adr0_i)) pend0_o = 1'b1;
            if (ent_vld[i] && (fifo_adr[i] == read_adr1_i)) pend1_o = 1'b1;
        end
        if (write_valid_o && (write_adr_o == read_adr0_i)) pend0_o = 1'b1;
        if (write_valid_o && (write_adr_o == read_adr1_i)) pend1_o = 1'b1;
        if (read_adr0_i == 6'd0) pend0_o = 1'b0;
        if (read_adr1_i == 6'd0) pend1_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            starv_cnt     <= '0;
            write_valid_o <= 1'b0;
            write_adr_o   <= '0;
            write_data_o  <= '0;
        end else begin
            if (push)       wr_ptr <= wr_ptr + PW'(1);
            if (grant_fifo) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(grant_fifo);

            if (grant_fifo || !fifo_nempty) begin
                starv_cnt <= '0;
            end else if (grant_alu && (starv_cnt != SW'(STARVE_LIMIT))) begin
                starv_cnt <= starv_cnt + SW'(1);
            end

            if (grant_alu) begin
                write_valid_o <= (alu_adr_i != 6'd0);
                write_adr_o   <= alu_adr_i;
                write_data_o  <= alu_data_i;
            end else if (grant_fifo) begin
                write_valid_o <= 1'b1;
                write_adr_o   <= fifo_adr[rd_ptr];
                write_data_o  <= fifo_dat[rd_ptr];
            end else begin
                write_valid_o <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_adr[wr_ptr] <= lsu_adr_i;
            fifo_dat[wr_ptr] <= lsu_data_i;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle, plus directed literal checks.
module tb_regfile_writeback;
    localparam int XLEN         = 32;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [5:0]      alu_adr;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [5:0]      lsu_adr;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic [5:0]      read_adr0;
    logic [5:0]      read_adr1;
    logic            pend0;
    logic            pend1;
    logic            write_valid;
    logic [5:0]      write_adr;
    logic [XLEN-1:0] write_data;

    int checks   = 0;
    int failures = 0;

    regfile_writeback #(
        .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid_i(alu_valid), .alu_adr_i(alu_adr), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .lsu_valid_i(lsu_valid), .lsu_adr_i(lsu_adr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
        .read_adr0_i(read_adr0), .read_adr1_i(read_adr1), .pend0_o(pend0), .pend1_o(pend1),
        .write_valid_o(write_valid), .write_adr_o(write_adr), .write_data_o(write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending loads as a plain queue, output register as three variables.
    typedef struct packed {
        logic [5:0]      adr;
        logic [XLEN-1:0] dat;
    } ent_t;

    ent_t            m_q[$];
    int              m_starv = 0;
    logic            m_wv = 1'b0;
    logic [5:0]      m_wa = '0;
    logic [XLEN-1:0] m_wd = '0;

    function automatic logic m_forced();
        return (m_q.size() > 0) && (m_starv == STARVE_LIMIT);
    endfunction

    function automatic logic m_pend(input logic [5:0] a);
        logic hit;
        hit = m_wv && (m_wa == a);
        foreach (m_q[i]) if (m_q[i].adr == a) hit = 1'b1;
        return (a != 6'd0) && hit;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_starv = 0;
            m_wv = 1'b0;
            m_wa = '0;
            m_wd = '0;
        end else begin
            int   n;
            ent_t e;
            n = m_q.size();
            if (alu_valid && !m_forced()) begin
                m_wv = (alu_adr != 6'd0);
                m_wa = alu_adr;
                m_wd = alu_data;
                m_starv = (n == 0) ? 0 : ((m_starv + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starv + 1);
            end else if (n > 0) begin
                e = m_q.pop_front();
                m_wv = 1'b1;
                m_wa = e.adr;
                m_wd = e.dat;
                m_starv = 0;
            end else begin
                m_wv = 1'b0;
                m_starv = 0;
            end
            if (lsu_valid && (n != FIFO_DEPTH) && (lsu_adr != 6'd0))
                m_q.push_back('{adr: lsu_adr, dat: lsu_data});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("m_alu_ready", alu_ready, !m_forced());
            check("m_lsu_ready", lsu_ready, m_q.size() != FIFO_DEPTH);
            check("m_write_valid", write_valid, m_wv);
            check("m_write_adr", write_adr, m_wa);
            check("m_write_data", write_data, m_wd);
            check("m_pend0", pend0, m_pend(read_adr0));
            check("m_pend1", pend1, m_pend(read_adr1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_adr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_adr = '0; lsu_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        read_adr0 = 6'd7;
        read_adr1 = 6'd0;
        step();
        step();
        reset = 1'b0;
        check("rst_write_valid", write_valid, 1'b0);
        check("rst_write_adr", write_adr, 6'd0);
        check("rst_lsu_ready", lsu_ready, 1'b1);
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_pend0", pend0, 1'b0);

        // ALU path
        alu_valid = 1'b1; alu_adr = 6'd5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check("alu_wv", write_valid, 1'b1);
        check("alu_wa", write_adr, 6'd5);
        check("alu_wd", write_data, 32'hDEADBEEF);
        step();
        check("alu_wv_drop", write_valid, 1'b0);
        check("alu_wa_hold", write_adr, 6'd5);

        // x0 handling
        alu_valid = 1'b1; alu_adr = 6'd0; alu_data = 32'h1234;
        step();
        idle_inputs();
        check("x0_alu_wv", write_valid, 1'b0);
        lsu_valid = 1'b1; lsu_adr = 6'd0; lsu_data = 32'h55;
        check("x0_lsu_ready", lsu_ready, 1'b1);
        step();
        idle_inputs();
        step();
        check("x0_lsu_nowrite", write_valid, 1'b0);
        check("x0_lsu_count", lsu_ready, 1'b1);

        // Hazard on a queued load to x7
        lsu_valid = 1'b1; lsu_adr = 6'd7; lsu_data = 32'h77;
        step();
        idle_inputs();
        check("haz_pend0_queued", pend0, 1'b1);
        check("haz_pend1_x0", pend1, 1'b0);
        check("haz_not_yet", write_valid, 1'b0);
        step();
        check("haz_wv", write_valid, 1'b1);
        check("haz_wa", write_adr, 6'd7);
        check("haz_wd", write_data, 32'h77);
        check("haz_pend0_outreg", pend0, 1'b1);
        step();
        check("haz_pend0_clear", pend0, 1'b0);

        // Fill the FIFO under continuous ALU traffic
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_adr = 6'(10 + i); alu_data = 32'hA000_0000 + i;
            lsu_valid = 1'b1; lsu_adr = 6'(i); lsu_data = 32'h100 + i;
            step();
            check("fill_alu_wa", write_adr, 6'(10 + i));
        end
        check("fill_full", lsu_ready, 1'b0);
        lsu_valid = 1'b0;
        alu_adr = 6'd15; alu_data = 32'hA000_0005;
        step();
        check("starve_force", alu_ready, 1'b0);
        lsu_valid = 1'b1; lsu_adr = 6'd5; lsu_data = 32'h105;
        check("full_pop_ready", lsu_ready, 1'b0);
        alu_adr = 6'd16; alu_data = 32'hA000_0006;
        step();
        check("force_wa", write_adr, 6'd1);
        check("force_wd", write_data, 32'h101);
        check("force_alu_ready", alu_ready, 1'b1);
        check("after_pop_ready", lsu_ready, 1'b1);
        alu_adr = 6'd17; alu_data = 32'hA000_0007;
        step();
        check("refill_alu_wa", write_adr, 6'd17);
        check("refill_full", lsu_ready, 1'b0);
        idle_inputs();
        for (int i = 2; i <= 5; i++) begin
            step();
            check("drain_wv", write_valid, 1'b1);
            check("drain_wa", write_adr, 6'(i));
            check("drain_wd", write_data, 32'h100 + i);
        end
        step();
        check("drain_done", write_valid, 1'b0);

        // Reset mid-traffic with three loads queued
        read_adr0 = 6'd20;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_adr = 6'(30 + i); alu_data = 32'hB000_0000 + i;
            lsu_valid = 1'b1; lsu_adr = 6'(20 + i); lsu_data = 32'h200 + i;
            step();
        end
        check("pre_rst_pend0", pend0, 1'b1);
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("mrst_wv", write_valid, 1'b0);
        check("mrst_lsu_ready", lsu_ready, 1'b1);
        check("mrst_pend0", pend0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("mrst_no_stale_write", write_valid && (write_adr >= 6'd20) && (write_adr <= 6'd22), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
